// File: rtl/ppu_pkg.sv
// Shared PPU-side types and constants used by the OAM DMA controller.
// Holds the DMA state encoding and the CPU register address that triggers a transfer.
// No logic here; imported by the DMA block.
package ppu_pkg;

    // DMA sequencing states; each state lasts one enabled CPU cycle
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_t;

    // CPU write address that starts a transfer
    localparam logic [15:0] DMA_REG_ADDR = 16'h4014;

    // Bytes copied per transfer (one CPU page)
    localparam int OAM_DEPTH = 256;

endpackage

// File: rtl/oam_dma_if.sv
// Bundle of CPU-bus, CPU-halt and OAM-write signals around the OAM DMA controller.
// The slave modport is the DMA block; the master modport is the CPU/bus/OAM side.
// Pure wiring; no storage.
interface oam_dma_if;
    // CPU side
    logic        cpu_cycle_en;
    logic        cpu_wr_v;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  oam_base;
    logic        cpu_rdy;
    logic        dma_busy;
    // CPU bus read path
    logic        dma2bus_v;
    logic [15:0] dma2bus_addr;
    logic [7:0]  bus2dma_data;
    // OAM write path
    logic        dma2oam_we;
    logic [7:0]  dma2oam_addr;
    logic [7:0]  dma2oam_data;

    modport slave (
        input  cpu_cycle_en,
        input  cpu_wr_v,
        input  cpu_addr,
        input  cpu_wdata,
        input  oam_base,
        input  bus2dma_data,
        output cpu_rdy,
        output dma_busy,
        output dma2bus_v,
        output dma2bus_addr,
        output dma2oam_we,
        output dma2oam_addr,
        output dma2oam_data
    );

    modport master (
        output cpu_cycle_en,
        output cpu_wr_v,
        output cpu_addr,
        output cpu_wdata,
        output oam_base,
        output bus2dma_data,
        input  cpu_rdy,
        input  dma_busy,
        input  dma2bus_v,
        input  dma2bus_addr,
        input  dma2oam_we,
        input  dma2oam_addr,
        input  dma2oam_data
    );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA ($4014): copies one CPU page into primary OAM while holding the CPU halted.
// Latency: 513 CPU cycles of stall from a get-cycle trigger, 514 from a put-cycle trigger.
// No backpressure: the bus read data is assumed valid in the READ cycle; the CPU waits on cpu_rdy.
module oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR = ppu_pkg::DMA_REG_ADDR,
    parameter int          OAM_DEPTH    = ppu_pkg::OAM_DEPTH
) (
    input  logic       clock,
    input  logic       reset_n,
    oam_dma_if.slave   bus
);
    import ppu_pkg::*;

    localparam int CNT_W = $clog2(OAM_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OAM_DEPTH - 1);

    dma_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             parity;     // 0 = get cycle, 1 = put cycle
    logic [7:0]       page;
    logic [7:0]       base;
    logic [7:0]       byte_q;
    logic             rdy_q;
    logic             busy_q;

    logic             trigger;
    logic             bus_v;
    logic             oam_we;

    // Only a write to the DMA register while idle starts a transfer
    assign trigger = bus.cpu_wr_v && (bus.cpu_addr == DMA_REG_ADDR);

    // State, counter, parity and latches; everything advances only on a CPU-cycle enable
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            parity <= 1'b0;
            page   <= 8'h00;
            base   <= 8'h00;
            byte_q <= 8'h00;
            rdy_q  <= 1'b1;
            busy_q <= 1'b0;
        end else if (bus.cpu_cycle_en) begin
            parity <= ~parity;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        page   <= bus.cpu_wdata;
                        base   <= bus.oam_base;
                        state  <= HALT;
                        rdy_q  <= 1'b0;
                        busy_q <= 1'b1;
                    end
                end
                // A put cycle now means the next cycle is a get, so reading can start at once
                HALT: state <= parity ? READ : ALIGN;
                ALIGN: state <= READ;
                READ: begin
                    byte_q <= bus.bus2dma_data;
                    state  <= WRITE;
                end
                WRITE: begin
                    if (cnt == CNT_LAST) begin
                        cnt    <= '0;
                        state  <= IDLE;
                        rdy_q  <= 1'b1;
                        busy_q <= 1'b0;
                    end else begin
                        cnt   <= cnt + CNT_W'(1);
                        state <= READ;
                    end
                end
                default: begin
                    state  <= IDLE;
                    rdy_q  <= 1'b1;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Strobes are qualified by the enable so each fires once per CPU cycle, not per PPU clock
    always_comb begin
        bus_v  = 1'b0;
        oam_we = 1'b0;
        if (bus.cpu_cycle_en) begin
            bus_v  = (state == READ);
            oam_we = (state == WRITE);
        end
    end

    assign bus.cpu_rdy      = rdy_q;
    assign bus.dma_busy     = busy_q;
    assign bus.dma2bus_v    = bus_v;
    assign bus.dma2bus_addr = {page, cnt};
    assign bus.dma2oam_we   = oam_we;
    // 8-bit add wraps past 255 so every OAM byte is hit once whatever the start address
    assign bus.dma2oam_addr = base + cnt;
    assign bus.dma2oam_data = byte_q;

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: a directed vector table for the first cycles of a transfer,
// then whole transfers compared against a page-copy model (expected OAM image, read order, stall).
// Bus read data is a keyed function of the requested address.
module tb_oam_dma;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    oam_dma_if bus();

    oam_dma dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [7:0] key = 8'h00;
    assign bus.bus2dma_data = bus.dma2bus_addr[7:0] ^ key;

    int errors = 0;
    int checks = 0;
    int par = 0;          // model of the get/put parity: enabled cycles since reset, mod 2
    int idle_mode = 0;    // idle clocks between CPU cycles; -1 = random 0..3

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    logic        mon_on = 1'b0;
    int          n_stall = 0;
    int          n_stray = 0;
    logic [7:0]  wr_addr_q[$];
    logic [7:0]  wr_data_q[$];
    logic [15:0] rd_addr_q[$];

    always @(negedge clock) begin
        if (mon_on) begin
            if ((bus.dma2oam_we || bus.dma2bus_v) && !bus.cpu_cycle_en) n_stray++;
            if (bus.cpu_cycle_en && reset_n) begin
                if (!bus.cpu_rdy) n_stall++;
                if (bus.dma2oam_we) begin
                    wr_addr_q.push_back(bus.dma2oam_addr);
                    wr_data_q.push_back(bus.dma2oam_data);
                end
                if (bus.dma2bus_v) rd_addr_q.push_back(bus.dma2bus_addr);
            end
        end
    end

    task automatic mon_clear();
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
        n_stall = 0;
        n_stray = 0;
    endtask

    // ---------------- drivers ----------------
    task automatic clk1(input logic en, input logic wr, input logic [15:0] a, input logic [7:0] d);
        bus.cpu_cycle_en = en;
        bus.cpu_wr_v     = wr;
        bus.cpu_addr     = a;
        bus.cpu_wdata    = d;
        @(posedge clock);
        #1;
        if (!reset_n) par = 0;
        else if (en) par = par ^ 1;
        bus.cpu_cycle_en = 1'b0;
        bus.cpu_wr_v     = 1'b0;
    endtask

    task automatic cpu_cyc(input logic wr, input logic [15:0] a, input logic [7:0] d);
        int n;
        n = (idle_mode < 0) ? int'($urandom_range(0, 3)) : idle_mode;
        repeat (n) clk1(1'b0, 1'b0, 16'h0000, 8'h00);
        clk1(1'b1, wr, a, d);
    endtask

    // One full transfer checked against the page-copy model
    task automatic run_xfer(input string tag, input logic [7:0] page, input logic [7:0] base,
                            input int want_put, input bit retrig, input bit gap);
        logic [7:0] exp_oam[256];
        logic [7:0] got_oam[256];
        int         hits[256];
        int         bad_rd, bad_wr, bad_oam, exp_stall;
        bit         done, retrig_done, gap_done;
        logic [31:0] snap;
        int          snap_n;

        if (par != want_put) cpu_cyc(1'b0, 16'h0000, 8'h00);
        mon_clear();
        mon_on = 1'b1;
        bus.oam_base = base;
        cpu_cyc(1'b1, 16'h4014, page);
        bus.oam_base = 8'($urandom);
        exp_stall = (want_put != 0) ? 514 : 513;
        done = 0; retrig_done = 0; gap_done = 0;
        for (int k = 0; k < 3000 && !done; k++) begin
            if (retrig && !retrig_done && wr_addr_q.size() == 100) begin
                cpu_cyc(1'b1, 16'h4014, page ^ 8'h5A);
                retrig_done = 1;
            end else if (gap && !gap_done && wr_addr_q.size() == 128) begin
                snap   = {bus.dma2bus_addr, bus.dma2oam_addr, 6'd0, bus.cpu_rdy, bus.dma_busy};
                snap_n = wr_addr_q.size() + rd_addr_q.size();
                repeat (10) clk1(1'b0, 1'b0, 16'h0000, 8'h00);
                check({tag, "_gap_hold"},
                      {bus.dma2bus_addr, bus.dma2oam_addr, 6'd0, bus.cpu_rdy, bus.dma_busy}, snap);
                check({tag, "_gap_strobes"}, wr_addr_q.size() + rd_addr_q.size(), snap_n);
                gap_done = 1;
            end else begin
                cpu_cyc(1'b0, 16'h0000, 8'h00);
            end
            if (bus.cpu_rdy) done = 1;
        end
        mon_on = 1'b0;
        check({tag, "_done"}, done, 1);

        for (int i = 0; i < 256; i++) begin
            exp_oam[(int'(base) + i) % 256] = 8'(i) ^ key;
            hits[i] = 0;
            got_oam[i] = 8'h00;
        end
        bad_rd = 0; bad_wr = 0; bad_oam = 0;
        foreach (rd_addr_q[i]) if (rd_addr_q[i] != {page, 8'(i)}) bad_rd++;
        foreach (wr_addr_q[i]) begin
            if (wr_addr_q[i] != 8'((int'(base) + i) % 256)) bad_wr++;
            hits[wr_addr_q[i]]++;
            got_oam[wr_addr_q[i]] = wr_data_q[i];
        end
        for (int a = 0; a < 256; a++) if (hits[a] != 1 || got_oam[a] != exp_oam[a]) bad_oam++;

        check({tag, "_stall"},      n_stall, exp_stall);
        check({tag, "_writes"},     wr_addr_q.size(), 256);
        check({tag, "_reads"},      rd_addr_q.size(), 256);
        check({tag, "_read_order"}, bad_rd, 0);
        check({tag, "_write_order"}, bad_wr, 0);
        check({tag, "_oam_image"},  bad_oam, 0);
        check({tag, "_stray"},      n_stray, 0);
        check({tag, "_idle_after"}, {bus.cpu_rdy, bus.dma_busy, bus.dma2bus_addr[7:0]}, {1'b1, 1'b0, 8'h00});
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        en;
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  base;
        logic        exp_rdy;
        logic        exp_busy;
        logic        exp_v;
        logic        exp_we;
        logic [15:0] exp_baddr;
        logic [7:0]  exp_oaddr;
    } vec_t;

    vec_t tbl[10];

    initial begin
        bus.cpu_cycle_en = 1'b0;
        bus.cpu_wr_v     = 1'b0;
        bus.cpu_addr     = 16'h0000;
        bus.cpu_wdata    = 8'h00;
        bus.oam_base     = 8'h00;

        // en wr addr wdata base | rdy busy v we baddr oaddr (outputs seen before the edge)
        tbl[0] = '{1'b0, 1'b1, 16'h4014, 8'h05, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00};
        tbl[1] = '{1'b1, 1'b1, 16'h4015, 8'h05, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00};
        tbl[2] = '{1'b1, 1'b0, 16'h4014, 8'h05, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00};
        tbl[3] = '{1'b1, 1'b1, 16'h4014, 8'h05, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00};
        tbl[4] = '{1'b1, 1'b0, 16'h0000, 8'h00, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0500, 8'h10};
        tbl[5] = '{1'b0, 1'b0, 16'h0000, 8'h00, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0500, 8'h10};
        tbl[6] = '{1'b1, 1'b0, 16'h0000, 8'h00, 8'h77, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0500, 8'h10};
        tbl[7] = '{1'b0, 1'b0, 16'h0000, 8'h00, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0500, 8'h10};
        tbl[8] = '{1'b1, 1'b1, 16'h4014, 8'h07, 8'h77, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0500, 8'h10};
        tbl[9] = '{1'b1, 1'b0, 16'h0000, 8'h00, 8'h77, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0501, 8'h11};

        // Reset state
        repeat (3) clk1(1'b1, 1'b0, 16'h0000, 8'h00);
        check("reset_state",
              {bus.cpu_rdy, bus.dma_busy, bus.dma2bus_v, bus.dma2oam_we,
               bus.dma2bus_addr, bus.dma2oam_addr, bus.dma2oam_data},
              {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00});
        reset_n = 1'b1;

        // Directed start of a transfer, cycle by cycle
        foreach (tbl[i]) begin
            bus.cpu_cycle_en = tbl[i].en;
            bus.cpu_wr_v     = tbl[i].wr;
            bus.cpu_addr     = tbl[i].addr;
            bus.cpu_wdata    = tbl[i].wdata;
            bus.oam_base     = tbl[i].base;
            @(negedge clock);
            check($sformatf("vec%0d", i),
                  {bus.cpu_rdy, bus.dma_busy, bus.dma2bus_v, bus.dma2oam_we, bus.dma2bus_addr, bus.dma2oam_addr},
                  {tbl[i].exp_rdy, tbl[i].exp_busy, tbl[i].exp_v, tbl[i].exp_we, tbl[i].exp_baddr, tbl[i].exp_oaddr});
            @(posedge clock);
            #1;
            if (tbl[i].en) par = par ^ 1;
            bus.cpu_cycle_en = 1'b0;
            bus.cpu_wr_v     = 1'b0;
        end

        // Reset mid-transfer, coincident with a trigger write: reset wins
        reset_n = 1'b0;
        clk1(1'b1, 1'b1, 16'h4014, 8'h33);
        reset_n = 1'b1;
        check("reset_wins",
              {bus.cpu_rdy, bus.dma_busy, bus.dma2bus_addr, bus.dma2oam_data},
              {1'b1, 1'b0, 16'h0000, 8'h00});

        // Get-cycle and put-cycle triggers, low-byte bus data
        key = 8'h00;
        idle_mode = 0;
        run_xfer("get", 8'h02, 8'h00, 0, 1'b0, 1'b0);
        run_xfer("put", 8'h02, 8'h00, 1, 1'b0, 1'b0);

        // Page FF with OAM start FC: both address spaces wrap
        key = 8'hA5;
        run_xfer("wrap", 8'hFF, 8'hFC, 0, 1'b0, 1'b0);
        if (wr_addr_q.size() == 256 && rd_addr_q.size() == 256) begin
            check("wrap_first", {rd_addr_q[0], wr_addr_q[0]}, {16'hFF00, 8'hFC});
            check("wrap_fifth", wr_addr_q[4], 8'h00);
            check("wrap_last", {rd_addr_q[255], wr_addr_q[255]}, {16'hFFFF, 8'hFB});
        end

        // Retrigger during the transfer is ignored
        key = 8'h3C;
        run_xfer("retrig", 8'h31, 8'h40, 1, 1'b1, 1'b0);

        // Reset at byte 37
        key = 8'h11;
        if (par != 0) cpu_cyc(1'b0, 16'h0000, 8'h00);
        mon_clear();
        mon_on = 1'b1;
        bus.oam_base = 8'h20;
        cpu_cyc(1'b1, 16'h4014, 8'h44);
        for (int k = 0; k < 400 && wr_addr_q.size() < 37; k++) cpu_cyc(1'b0, 16'h0000, 8'h00);
        check("abort_reached", wr_addr_q.size(), 37);
        reset_n = 1'b0;
        clk1(1'b1, 1'b0, 16'h0000, 8'h00);
        reset_n = 1'b1;
        check("abort_idle", {bus.cpu_rdy, bus.dma_busy}, {1'b1, 1'b0});
        mon_clear();
        repeat (30) cpu_cyc(1'b0, 16'h0000, 8'h00);
        check("abort_quiet", wr_addr_q.size() + rd_addr_q.size() + n_stall, 0);
        mon_on = 1'b0;
        run_xfer("restart", 8'h44, 8'h20, 0, 1'b0, 1'b0);

        // Sparse enables with a long gap mid-transfer
        idle_mode = 2;
        key = 8'h5E;
        run_xfer("sparse", 8'h80, 8'h81, 1, 1'b0, 1'b1);

        // Randomised transfers
        idle_mode = -1;
        for (int r = 0; r < 4; r++) begin
            key = 8'($urandom);
            run_xfer($sformatf("rnd%0d", r), 8'($urandom), 8'($urandom),
                     int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
